// File: rtl/wsp_pkg.sv
// Shared types and constants for the IEEE 1500 wrapper serial port sequencer.
package wsp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_DONE    = 3'd4
  } wsp_state_e;

  // cmd_type encodings
  localparam logic CMD_WIR = 1'b0;
  localparam logic CMD_WBR = 1'b1;

  // WIR opcodes
  localparam logic [2:0] WS_BYPASS = 3'b000;
  localparam logic [2:0] WS_EXTEST = 3'b001;
  localparam logic [2:0] WS_INTEST = 3'b010;

  // Instruction register length in bits
  localparam int WIR_LEN = 3;

endpackage

// File: rtl/wsp_shift_unit.sv
// Payload shifter, bit counter and WSO collector for one scan command.
module wsp_shift_unit #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              WRSTN,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              shift,
  input  logic              wso,
  output logic              wsi_bit,
  output logic              last_bit,
  output logic              len_zero,
  output logic [DATA_W-1:0] rsp_data
);

  logic [DATA_W-1:0] payload_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  len_q;

  // Payload moves right so the current bit is always at index 0.
  assign wsi_bit  = payload_q[0];
  assign last_bit = (cnt_q == (len_q - LEN_W'(1)));
  assign len_zero = (len_q == '0);

  // Load on accept; during shift advance payload/counter and drop WSO into rsp_data[cnt].
  always_ff @(posedge clk) begin
    if (!WRSTN) begin
      payload_q <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      rsp_data  <= '0;
    end else if (load) begin
      payload_q <= load_data;
      len_q     <= load_len;
      cnt_q     <= '0;
      rsp_data  <= '0;
    end else if (shift) begin
      payload_q <= payload_q >> 1;
      cnt_q     <= cnt_q + LEN_W'(1);
      for (int k = 0; k < DATA_W; k++) begin
        if (cnt_q == LEN_W'(k)) rsp_data[k] <= wso;
      end
    end
  end

endmodule

// File: rtl/wsp_sequencer.sv
// WSP sequencer: runs capture/shift/update on WRCK for WIR loads and WBR scans.
module wsp_sequencer
  import wsp_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 5
) (
  input  logic              WRCK,
  input  logic              WRSTN,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_type,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        wir_value,
  output logic              SelectWIR,
  output logic              CaptureWR,
  output logic              ShiftWR,
  output logic              UpdateWR,
  output logic              WSI,
  input  logic              WSO
);

  wsp_state_e       state_q, state_d;
  logic             type_q;
  logic [2:0]       wir_lo_q;
  logic [LEN_W-1:0] eff_len;
  logic             accept;
  logic             wsi_bit, last_bit, len_zero;

  assign accept = cmd_valid && (state_q == ST_IDLE);

  // Instructions are always WIR_LEN long; scans clamp to the register width.
  always_comb begin
    eff_len = cmd_len;
    if (cmd_type == CMD_WIR)                 eff_len = LEN_W'(WIR_LEN);
    else if (cmd_len > LEN_W'(DATA_W))       eff_len = LEN_W'(DATA_W);
  end

  wsp_shift_unit #(.DATA_W(DATA_W), .LEN_W(LEN_W)) u_shift (
    .clk       (WRCK),
    .WRSTN     (WRSTN),
    .load      (accept),
    .load_data (cmd_data),
    .load_len  (eff_len),
    .shift     (state_q == ST_SHIFT),
    .wso       (WSO),
    .wsi_bit   (wsi_bit),
    .last_bit  (last_bit),
    .len_zero  (len_zero),
    .rsp_data  (rsp_data)
  );

  // State register, latched command fields and the WIR shadow value.
  always_ff @(posedge WRCK) begin
    if (!WRSTN) begin
      state_q   <= ST_IDLE;
      type_q    <= CMD_WIR;
      wir_lo_q  <= '0;
      wir_value <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q   <= cmd_type;
        wir_lo_q <= cmd_data[2:0];
      end
      if (state_q == ST_UPDATE && type_q == CMD_WIR) wir_value <= wir_lo_q;
    end
  end

  // Next-state and Moore output decode from the registered state.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    CaptureWR = 1'b0;
    ShiftWR   = 1'b0;
    UpdateWR  = 1'b0;
    rsp_valid = 1'b0;
    SelectWIR = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        CaptureWR = 1'b1;
        SelectWIR = (type_q == CMD_WIR);
        state_d   = len_zero ? ST_UPDATE : ST_SHIFT;
      end
      ST_SHIFT: begin
        ShiftWR   = 1'b1;
        SelectWIR = (type_q == CMD_WIR);
        if (last_bit) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        UpdateWR  = 1'b1;
        SelectWIR = (type_q == CMD_WIR);
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    WSI = ShiftWR & wsi_bit;
  end

endmodule
